// File: rtl/imem_loader_ctrl_if.sv
// Load-command, instruction-stream and imem debug-write bundle for imem_loader_ctrl.
// The controller connects through the slave modport.
// A host/testbench driving commands and the stream uses the master modport.
interface imem_loader_ctrl_if #(
    parameter int INSTRUCTION_LENGTH     = 32,
    parameter int SIMULATION_MEMORY_SIZE = 6
);
    // load command
    logic                              start;
    logic [SIMULATION_MEMORY_SIZE-1:0] base_addr;
    logic [SIMULATION_MEMORY_SIZE-1:0] word_count;
    // instruction word stream
    logic                              in_valid;
    logic [INSTRUCTION_LENGTH-1:0]     in_instr;
    logic                              in_ready;
    // instruction memory debug write port
    logic                              dbg_wr_en;
    logic [SIMULATION_MEMORY_SIZE-1:0] dbg_addr;
    logic [INSTRUCTION_LENGTH-1:0]     dbg_instr;
    // status
    logic                              cpu_stall;
    logic                              busy;
    logic                              done;
    logic                              error;

    modport slave (
        input  start, base_addr, word_count, in_valid, in_instr,
        output in_ready, dbg_wr_en, dbg_addr, dbg_instr, cpu_stall, busy, done, error
    );

    modport master (
        output start, base_addr, word_count, in_valid, in_instr,
        input  in_ready, dbg_wr_en, dbg_addr, dbg_instr, cpu_stall, busy, done, error
    );
endinterface

// File: rtl/imem_loader_ctrl.sv
// Instruction memory loader.
// Takes a (base, count) command, then streams words into consecutive imem
// addresses through the debug write port.
// The CPU is held in stall for the duration of the load.
module imem_loader_ctrl #(
    parameter int XLEN                   = 64,
    parameter int INSTRUCTION_LENGTH     = XLEN / 2,
    parameter int SIMULATION_MEMORY_SIZE = 6
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_ctrl_if.slave bus
);
    localparam int AW    = SIMULATION_MEMORY_SIZE;
    localparam int DEPTH = 2 ** (AW - 1);
    // DEPTH at AW+1 bits, so it compares directly against the end address.
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t                        state_q;
    logic [AW-1:0]                 ptr_q;
    logic [AW-1:0]                 rem_q;
    logic                          wr_en_q;
    logic [AW-1:0]                 addr_q;
    logic [INSTRUCTION_LENGTH-1:0] instr_q;
    logic                          done_q;
    logic                          error_q;

    // One extra bit so a base near the top plus a large count cannot wrap
    // back into range.
    logic [AW:0] end_addr;
    logic        handshake;

    assign end_addr  = {1'b0, bus.base_addr} + {1'b0, bus.word_count};
    assign handshake = bus.in_valid && (state_q == LOAD);

    // Handshake/status flags depend only on the state register.
    // Nothing here reaches back to the inputs combinationally.
    assign bus.in_ready  = (state_q == LOAD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.cpu_stall = (state_q != IDLE);
    assign bus.dbg_wr_en = wr_en_q;
    assign bus.dbg_addr  = addr_q;
    assign bus.dbg_instr = instr_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;

    // Load sequencer: command acceptance, write pointer, registered debug write, done/error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (end_addr > DEPTH_L) begin
                            // Rejected: report immediately and never leave IDLE,
                            // so the CPU is not stalled.
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (bus.word_count == '0) begin
                            error_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            error_q <= 1'b0;
                            ptr_q   <= bus.base_addr;
                            rem_q   <= bus.word_count;
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        wr_en_q <= 1'b1;
                        addr_q  <= ptr_q;
                        instr_q <= bus.in_instr;
                        ptr_q   <= ptr_q + 1'b1;
                        rem_q   <= rem_q - 1'b1;
                        if (rem_q == AW'(1)) state_q <= FLUSH;
                    end
                end
                // The last write is on the debug port during this cycle.
                FLUSH: begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Self-checking bench for imem_loader_ctrl.
// Directed scenarios come first, then random loads.
// Expected write addresses/data and final memory contents come from a
// reference array updated from the load rules.
module tb_imem_loader_ctrl;
    localparam int IL    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_ctrl_if #(.INSTRUCTION_LENGTH(IL), .SIMULATION_MEMORY_SIZE(AW)) bus ();

    imem_loader_ctrl #(.XLEN(64), .INSTRUCTION_LENGTH(IL), .SIMULATION_MEMORY_SIZE(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Instruction memory behind the debug port, and the reference image.
    logic [IL-1:0] imem     [DEPTH];
    logic [IL-1:0] ref_mem  [DEPTH];
    int            nwrites  = 0;
    int            exp_wr   = 0;
    logic [IL-1:0] fixed_w  [3];

    // The memory model latches whatever the debug port writes.
    always @(negedge clk) begin
        if (bus.dbg_wr_en === 1'b1) begin
            imem[bus.dbg_addr[AW-2:0]] = bus.dbg_instr;
            nwrites++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".in_ready"},  64'(bus.in_ready),  64'd0);
        chk({tag, ".wr_en"},     64'(bus.dbg_wr_en), 64'd0);
        chk({tag, ".addr"},      64'(bus.dbg_addr),  64'd0);
        chk({tag, ".instr"},     64'(bus.dbg_instr), 64'd0);
        chk({tag, ".stall"},     64'(bus.cpu_stall), 64'd0);
        chk({tag, ".busy"},      64'(bus.busy),      64'd0);
        chk({tag, ".done"},      64'(bus.done),      64'd0);
        chk({tag, ".error"},     64'(bus.error),     64'd0);
    endtask

    // gap_pct < 0 selects the fixed pattern: word0, two idle cycles, word1, word2.
    // poke re-asserts start with another base while the load is running.
    task automatic do_load(input int base, input int cnt, input int gap_pct,
                           input bit use_fixed, input bit poke);
        int            gap;
        logic [IL-1:0] w;
        bus.start      = 1'b1;
        bus.base_addr  = AW'(base);
        bus.word_count = AW'(cnt);
        tick();
        bus.start      = 1'b0;
        // Command fields only matter at the accepted start.
        bus.base_addr  = AW'($urandom);
        bus.word_count = AW'($urandom);
        if (base + cnt > DEPTH) begin
            chk("range.done",  64'(bus.done),      64'd1);
            chk("range.error", 64'(bus.error),     64'd1);
            chk("range.stall", 64'(bus.cpu_stall), 64'd0);
            chk("range.wr",    64'(bus.dbg_wr_en), 64'd0);
            tick();
            chk("range.done2",  64'(bus.done),      64'd0);
            chk("range.error2", 64'(bus.error),     64'd1);
            chk("range.busy2",  64'(bus.busy),      64'd0);
            return;
        end
        chk("start.error", 64'(bus.error),     64'd0);
        chk("start.stall", 64'(bus.cpu_stall), 64'd1);
        chk("start.busy",  64'(bus.busy),      64'd1);
        if (cnt == 0) begin
            chk("zero.done",  64'(bus.done),      64'd1);
            chk("zero.ready", 64'(bus.in_ready),  64'd0);
            chk("zero.wr",    64'(bus.dbg_wr_en), 64'd0);
            tick();
            chk("zero.done2", 64'(bus.done),      64'd0);
            chk("zero.busy2", 64'(bus.busy),      64'd0);
            chk("zero.wr2",   64'(bus.dbg_wr_en), 64'd0);
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            if (gap_pct < 0) gap = (i == 1) ? 2 : 0;
            else gap = (int'($urandom_range(99)) < gap_pct) ? int'($urandom_range(1, 3)) : 0;
            bus.in_valid = 1'b0;
            bus.in_instr = $urandom;
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap.wr",    64'(bus.dbg_wr_en), 64'd0);
                chk("gap.stall", 64'(bus.cpu_stall), 64'd1);
            end
            if (poke && i == 1) begin
                bus.start      = 1'b1;
                bus.base_addr  = AW'((base + 7) % DEPTH);
                bus.word_count = AW'(1);
            end
            chk("load.ready", 64'(bus.in_ready), 64'd1);
            w = use_fixed ? fixed_w[i] : IL'($urandom);
            bus.in_valid = 1'b1;
            bus.in_instr = w;
            tick();
            bus.in_valid = 1'b0;
            bus.start    = 1'b0;
            chk("wr.en",    64'(bus.dbg_wr_en), 64'd1);
            chk("wr.addr",  64'(bus.dbg_addr),  64'(base + i));
            chk("wr.instr", 64'(bus.dbg_instr), 64'(w));
            chk("wr.stall", 64'(bus.cpu_stall), 64'd1);
            ref_mem[base + i] = w;
            exp_wr++;
        end
        chk("flush.ready", 64'(bus.in_ready), 64'd0);
        chk("flush.done",  64'(bus.done),     64'd0);
        tick();
        chk("done.pulse", 64'(bus.done),      64'd1);
        chk("done.stall", 64'(bus.cpu_stall), 64'd1);
        chk("done.wr",    64'(bus.dbg_wr_en), 64'd0);
        tick();
        chk("idle.done",  64'(bus.done),      64'd0);
        chk("idle.stall", 64'(bus.cpu_stall), 64'd0);
        chk("idle.busy",  64'(bus.busy),      64'd0);
    endtask

    initial begin
        int base, cnt, snap;
        for (int i = 0; i < DEPTH; i++) begin
            imem[i]    = '0;
            ref_mem[i] = '0;
        end
        fixed_w[0] = 32'h0000_0013;
        fixed_w[1] = 32'h0010_0093;
        fixed_w[2] = 32'h0020_0113;
        bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
        bus.in_valid = 1'b0; bus.in_instr = '0;
        tick(); tick();
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk_all_zero("post_reset");

        do_load(4, 3, 0, 1'b1, 1'b0);    // back-to-back
        do_load(4, 3, -1, 1'b1, 1'b0);   // gapped valid
        do_load(30, 3, 0, 1'b0, 1'b0);   // end 33 > 32: rejected
        do_load(31, 1, 0, 1'b0, 1'b0);   // top address, clears error
        do_load(10, 0, 0, 1'b0, 1'b0);   // empty load
        do_load(12, 4, 30, 1'b0, 1'b1);  // start during LOAD ignored

        // Reset after the 2nd of 5 words.
        bus.start = 1'b1; bus.base_addr = AW'(20); bus.word_count = AW'(5);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = $urandom;
            ref_mem[20 + i] = bus.in_instr;
            exp_wr++;
            tick();
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        snap = nwrites;
        repeat (3) tick();
        chk("rst.no_writes", 64'(nwrites), 64'(snap));
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("rst.idle_busy", 64'(bus.busy), 64'd0);

        // Random loads, including some out of range.
        for (int n = 0; n < 12; n++) begin
            base = int'($urandom_range(DEPTH - 1));
            cnt  = int'($urandom_range(8));
            if (n % 4 == 3) cnt = DEPTH - base + int'($urandom_range(1, 4));
            do_load(base, cnt, 40, 1'b0, 1'b0);
        end

        tick();
        chk("total_writes", 64'(nwrites), 64'(exp_wr));
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("imem[%0d]", i), 64'(imem[i]), 64'(ref_mem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
